// File: rtl/serial_port_bridge.sv
// UART bridge for the CPU serial port: 16-bit words as byte pairs, low byte first.
// Define SERIAL_PARITY_EN for 8E1 framing; default build is 8N1.
module serial_port_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PAIR_TIMEOUT = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        SerialSend,
  input  logic [15:0] SerialDataOut,
  input  logic        SerialRead,
  input  logic        RxD,
  output logic        TxD,
  output logic        TxBusy,
  output logic        SerialValid,
  output logic [15:0] SerialDataIn,
  output logic        RxError
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PL = PAIR_TIMEOUT * CLKS_PER_BIT;
  localparam int PW = $clog2(PL);
  localparam logic [TW-1:0] BIT_END = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW-1:0] PAIR_END = PW'(PL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t        tx_state, tx_next;
  logic [TW-1:0] tx_timer;
  logic [2:0]    tx_bit;
  logic          tx_hi;
  logic [15:0]   tx_word;
  logic [7:0]    tx_byte;
  logic          tx_tick;
  logic          tx_line;

  assign tx_tick = tx_timer == BIT_END;
  assign tx_byte = tx_hi ? tx_word[15:8] : tx_word[7:0];

  always_ff @(posedge Clock) begin
    if (!Reset) tx_state <= S_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      S_IDLE:  if (SerialSend) tx_next = S_START;
      S_START: if (tx_tick) tx_next = S_DATA;
`ifdef SERIAL_PARITY_EN
      S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = S_PAR;
      S_PAR:   if (tx_tick) tx_next = S_STOP;
`else
      S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
`endif
      S_STOP:  if (tx_tick) tx_next = tx_hi ? S_IDLE : S_START;
      default: tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    unique case (tx_state)
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tx_byte[tx_bit];
`ifdef SERIAL_PARITY_EN
      S_PAR:   tx_line = ^tx_byte;
`endif
      default: tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_hi    <= 1'b0;
      tx_word  <= '0;
    end else begin
      if (tx_state == S_IDLE && SerialSend) begin
        tx_word <= SerialDataOut;
        tx_hi   <= 1'b0;
      end
      tx_timer <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_timer + 1'b1;
      if (tx_state == S_DATA && tx_tick) tx_bit <= tx_bit + 1'b1;
      if (tx_state == S_STOP && tx_tick) tx_hi <= ~tx_hi;
    end
  end

  assign TxD    = tx_line;
  assign TxBusy = tx_state != S_IDLE;

  state_t        rx_state, rx_next;
  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_fall;
  logic [TW-1:0] rx_timer;
  logic          rx_tick;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_shift_en;
  logic          rx_byte_done;
  logic          rx_frame_ok;
  logic          byte_good, byte_bad;
  logic          have_lo;
  logic [7:0]    lo_byte;
  logic [PW-1:0] pair_cnt;
  logic          pair_expire;
  logic          word_done, overrun;
`ifdef SERIAL_PARITY_EN
  logic          rx_par_en;
  logic          rx_par_bad;
`endif

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_tick = rx_timer == BIT_END;

  always_ff @(posedge Clock) begin
    if (!Reset) rx_state <= S_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_timer == HALF_END) rx_next = rx_s2 ? S_IDLE : S_DATA;
`ifdef SERIAL_PARITY_EN
      S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_PAR;
      S_PAR:   if (rx_tick) rx_next = S_STOP;
`else
      S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_STOP;
`endif
      S_STOP:  if (rx_tick) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_shift_en  = 1'b0;
    rx_byte_done = 1'b0;
`ifdef SERIAL_PARITY_EN
    rx_par_en    = 1'b0;
`endif
    unique case (rx_state)
      S_DATA:  rx_shift_en = rx_tick;
`ifdef SERIAL_PARITY_EN
      S_PAR:   rx_par_en = rx_tick;
`endif
      S_STOP:  rx_byte_done = rx_tick;
      default: rx_byte_done = 1'b0;
    endcase
  end

`ifdef SERIAL_PARITY_EN
  assign rx_frame_ok = rx_s2 & ~rx_par_bad;
`else
  assign rx_frame_ok = rx_s2;
`endif

  assign byte_good   = rx_byte_done & rx_frame_ok;
  assign byte_bad    = rx_byte_done & ~rx_frame_ok;
  assign word_done   = byte_good & have_lo;
  assign overrun     = word_done & SerialValid & ~SerialRead;
  // Timer pauses while a start bit is being qualified.
  assign pair_expire = have_lo && rx_state == S_IDLE
                    && !rx_fall && pair_cnt == PAIR_END;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      rx_timer     <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      have_lo      <= 1'b0;
      lo_byte      <= '0;
      pair_cnt     <= '0;
      SerialValid  <= 1'b0;
      SerialDataIn <= '0;
      RxError      <= 1'b0;
`ifdef SERIAL_PARITY_EN
      rx_par_bad   <= 1'b0;
`endif
    end else begin
      rx_s1   <= RxD;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (rx_state == S_IDLE || rx_tick || rx_state != rx_next)
        rx_timer <= '0;
      else
        rx_timer <= rx_timer + 1'b1;
      if (rx_shift_en) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
`ifdef SERIAL_PARITY_EN
      if (rx_par_en) rx_par_bad <= rx_s2 != ^rx_shift;
`endif
      if (byte_bad || word_done || pair_expire) begin
        have_lo <= 1'b0;
      end else if (byte_good) begin
        have_lo <= 1'b1;
        lo_byte <= rx_shift;
      end
      if (byte_good && !have_lo) pair_cnt <= '0;
      else if (!have_lo)         pair_cnt <= '0;
      else if (rx_state == S_IDLE) pair_cnt <= pair_cnt + 1'b1;
      if (word_done && !overrun) begin
        SerialDataIn <= {rx_shift, lo_byte};
        SerialValid  <= 1'b1;
      end else if (SerialRead) begin
        SerialValid <= 1'b0;
      end
      RxError <= byte_bad | overrun | pair_expire;
    end
  end

endmodule

// File: tb/tb_serial_port_bridge.sv
// Bench for serial_port_bridge: TX frame decoding and RX pairing/error scenarios.
// Build with SERIAL_PARITY_EN to cover the 8E1 frame.
module tb_serial_port_bridge;

  localparam int CPB = 8;
  localparam int PT  = 16;
`ifdef SERIAL_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        SerialSend = 1'b0;
  logic [15:0] SerialDataOut = '0;
  logic        SerialRead = 1'b0;
  logic        RxD = 1'b1;
  logic        TxD;
  logic        TxBusy;
  logic        SerialValid;
  logic [15:0] SerialDataIn;
  logic        RxError;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  logic [7:0]  exp_tx[$];
  logic [15:0] exp_rx[$];

  serial_port_bridge #(
    .CLKS_PER_BIT(CPB),
    .PAIR_TIMEOUT(PT)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .SerialSend(SerialSend),
    .SerialDataOut(SerialDataOut),
    .SerialRead(SerialRead),
    .RxD(RxD),
    .TxD(TxD),
    .TxBusy(TxBusy),
    .SerialValid(SerialValid),
    .SerialDataIn(SerialDataIn),
    .RxError(RxError)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (RxError === 1'b1) err_seen++;

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // fault: 0 clean, 1 stop bit low, 2 wrong parity
  task automatic rx_byte(input logic [7:0] b, input int fault,
                         input bit read_at_done);
    @(negedge Clock) RxD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      tick(CPB);
    end
`ifdef SERIAL_PARITY_EN
    RxD = (^b) ^ (fault == 2);
    tick(CPB);
`endif
    RxD = (fault != 1);
    if (read_at_done) begin
      tick(CPB / 2 + 2);
      SerialRead = 1'b1;
      tick(1);
      SerialRead = 1'b0;
      tick(CPB / 2 - 3);
    end else begin
      tick(CPB);
    end
    RxD = 1'b1;
  endtask

  task automatic read_word();
    @(negedge Clock) SerialRead = 1'b1;
    @(negedge Clock) SerialRead = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick(3);
    checks++;
    if (TxD !== 1'b1) begin
      errors++; $display("FAIL reset_txd got %b want 1", TxD);
    end
    checks++;
    if (TxBusy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", TxBusy);
    end
    checks++;
    if (SerialValid !== 1'b0 || SerialDataIn !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rx got v=%b d=%h want v=0 d=0000",
               SerialValid, SerialDataIn);
    end
    checks++;
    if (RxError !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", RxError);
    end
    Reset = 1'b1;
    tick(2);
  endtask

  task automatic tx_frame(input logic [15:0] w, input bit poke);
    logic [FB-1:0] f;
    logic [7:0]    e;
    bit            busy_ok;
    bit            idle_ok;
    exp_tx.push_back(w[7:0]);
    exp_tx.push_back(w[15:8]);
    busy_ok = 1'b1;
    @(negedge Clock);
    SerialDataOut = w;
    SerialSend = 1'b1;
    @(posedge Clock);
    #1 SerialSend = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < FB; k++) begin
        repeat (CPB / 2) @(posedge Clock);
        #1;
        f[k] = TxD;
        if (TxBusy !== 1'b1) busy_ok = 1'b0;
        if (poke && b == 0 && k == 1) begin
          SerialDataOut = 16'h1234;
          SerialSend = 1'b1;
        end
        repeat (CPB / 2) begin
          @(posedge Clock);
          #1 SerialSend = 1'b0;
        end
      end
      e = exp_tx.pop_front();
      checks++;
      if (f[0] !== 1'b0 || f[FB-1] !== 1'b1) begin
        errors++;
        $display("FAIL tx_framing byte%0d got start=%b stop=%b want 0/1",
                 b, f[0], f[FB-1]);
      end
      checks++;
      if (f[8:1] !== e) begin
        errors++;
        $display("FAIL tx_byte%0d got %h want %h", b, f[8:1], e);
      end
`ifdef SERIAL_PARITY_EN
      checks++;
      if (f[9] !== ^e) begin
        errors++;
        $display("FAIL tx_parity%0d got %b want %b", b, f[9], ^e);
      end
`endif
    end
    checks++;
    if (!busy_ok || TxBusy !== 1'b0 || TxD !== 1'b1) begin
      errors++;
      $display("FAIL tx_busy_window got held=%b end_busy=%b end_txd=%b want 1/0/1",
               busy_ok, TxBusy, TxD);
    end
    idle_ok = 1'b1;
    for (int c = 0; c < 3 * CPB * FB; c++) begin
      @(negedge Clock);
      if (TxBusy !== 1'b0 || TxD !== 1'b1) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin
      errors++;
      $display("FAIL tx_idle_after got line activity want none");
    end
  endtask

  task automatic test_tx();
    tx_frame(16'hA55A, 1'b0);
  endtask

  task automatic test_tx_ignore();
    tx_frame(16'hC33C, 1'b1);
  endtask

  task automatic test_rx_word();
    logic [15:0] e;
    int e0;
    e0 = err_seen;
    exp_rx.push_back(16'h1234);
    rx_byte(8'h34, 0, 1'b0);
    rx_byte(8'h12, 0, 1'b0);
    e = exp_rx.pop_front();
    checks++;
    if (SerialValid !== 1'b1 || SerialDataIn !== e) begin
      errors++;
      $display("FAIL rx_word got v=%b d=%h want v=1 d=%h",
               SerialValid, SerialDataIn, e);
    end
    checks++;
    if (err_seen != e0) begin
      errors++; $display("FAIL rx_word_err got %0d want 0", err_seen - e0);
    end
    @(negedge Clock) SerialRead = 1'b1;
    @(posedge Clock);
    #1;
    checks++;
    if (SerialValid !== 1'b0 || SerialDataIn !== e) begin
      errors++;
      $display("FAIL rx_read got v=%b d=%h want v=0 d=%h",
               SerialValid, SerialDataIn, e);
    end
    SerialRead = 1'b0;
    read_word();
    checks++;
    if (SerialValid !== 1'b0) begin
      errors++; $display("FAIL rx_idle_read got v=%b want 0", SerialValid);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] e;
    int e0;
    exp_rx.push_back(16'h1234);
    rx_byte(8'h34, 0, 1'b0);
    rx_byte(8'h12, 0, 1'b0);
    e = exp_rx.pop_front();
    e0 = err_seen;
    rx_byte(8'hEF, 0, 1'b0);
    rx_byte(8'hBE, 0, 1'b0);
    checks++;
    if (err_seen - e0 != 1) begin
      errors++; $display("FAIL overrun_err got %0d want 1", err_seen - e0);
    end
    checks++;
    if (SerialValid !== 1'b1 || SerialDataIn !== e) begin
      errors++;
      $display("FAIL overrun_keep got v=%b d=%h want v=1 d=%h",
               SerialValid, SerialDataIn, e);
    end
  endtask

  task automatic test_read_collision();
    logic [15:0] e;
    int e0;
    e0 = err_seen;
    exp_rx.push_back(16'hBEEF);
    rx_byte(8'hEF, 0, 1'b0);
    rx_byte(8'hBE, 0, 1'b1);
    e = exp_rx.pop_front();
    checks++;
    if (SerialValid !== 1'b1 || SerialDataIn !== e || err_seen != e0) begin
      errors++;
      $display("FAIL collision got v=%b d=%h errs=%0d want v=1 d=%h errs=0",
               SerialValid, SerialDataIn, err_seen - e0, e);
    end
    read_word();
  endtask

  task automatic test_pair_gap();
    logic [15:0] e;
    int e0;
    e0 = err_seen;
    exp_rx.push_back(16'hCAFE);
    rx_byte(8'hFE, 0, 1'b0);
    tick(10 * CPB);
    rx_byte(8'hCA, 0, 1'b0);
    e = exp_rx.pop_front();
    checks++;
    if (SerialValid !== 1'b1 || SerialDataIn !== e || err_seen != e0) begin
      errors++;
      $display("FAIL pair_gap got v=%b d=%h errs=%0d want v=1 d=%h errs=0",
               SerialValid, SerialDataIn, err_seen - e0, e);
    end
    read_word();
  endtask

  task automatic test_pair_timeout();
    logic [15:0] e;
    int e0;
    e0 = err_seen;
    rx_byte(8'h34, 0, 1'b0);
    tick((PT + 4) * CPB);
    checks++;
    if (err_seen - e0 != 1 || SerialValid !== 1'b0) begin
      errors++;
      $display("FAIL timeout got errs=%0d v=%b want errs=1 v=0",
               err_seen - e0, SerialValid);
    end
    exp_rx.push_back(16'h5678);
    rx_byte(8'h78, 0, 1'b0);
    rx_byte(8'h56, 0, 1'b0);
    e = exp_rx.pop_front();
    checks++;
    if (SerialValid !== 1'b1 || SerialDataIn !== e || err_seen - e0 != 1) begin
      errors++;
      $display("FAIL timeout_next got v=%b d=%h errs=%0d want v=1 d=%h errs=1",
               SerialValid, SerialDataIn, err_seen - e0, e);
    end
    read_word();
  endtask

  task automatic bad_frame(input int fault, input string tag);
    logic [15:0] e;
    int e0;
    e0 = err_seen;
    rx_byte(8'h34, 0, 1'b0);
    rx_byte(8'h12, fault, 1'b0);
    checks++;
    if (err_seen - e0 != 1 || SerialValid !== 1'b0) begin
      errors++;
      $display("FAIL %s got errs=%0d v=%b want errs=1 v=0",
               tag, err_seen - e0, SerialValid);
    end
    tick(2 * CPB);
    exp_rx.push_back(16'h5678);
    rx_byte(8'h78, 0, 1'b0);
    rx_byte(8'h56, 0, 1'b0);
    e = exp_rx.pop_front();
    checks++;
    if (SerialValid !== 1'b1 || SerialDataIn !== e || err_seen - e0 != 1) begin
      errors++;
      $display("FAIL %s_next got v=%b d=%h want v=1 d=%h",
               tag, SerialValid, SerialDataIn, e);
    end
  endtask

  task automatic test_framing();
    bad_frame(1, "framing");
    read_word();
`ifdef SERIAL_PARITY_EN
    bad_frame(2, "parity");
    read_word();
`endif
  endtask

  task automatic test_reset_mid();
    rx_byte(8'h34, 0, 1'b0);
    rx_byte(8'h12, 0, 1'b0);
    @(negedge Clock);
    SerialDataOut = 16'hAAAA;
    SerialSend = 1'b1;
    @(negedge Clock) SerialSend = 1'b0;
    tick(30);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    checks++;
    if (TxD !== 1'b1 || TxBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_tx got txd=%b busy=%b want 1/0", TxD, TxBusy);
    end
    checks++;
    if (SerialValid !== 1'b0 || SerialDataIn !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_rx got v=%b d=%h want v=0 d=0000",
               SerialValid, SerialDataIn);
    end
    @(negedge Clock) Reset = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_tx();
    test_tx_ignore();
    test_rx_word();
    test_overrun();
    test_read_collision();
    test_pair_gap();
    test_pair_timeout();
    test_framing();
    test_reset_mid();
    checks++;
    if (exp_tx.size() != 0 || exp_rx.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got tx=%0d rx=%0d want 0/0",
               exp_tx.size(), exp_rx.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
